// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester and memory-side signals of the shared memory port
interface mem_port_arbiter_if #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 8
);
  logic              if_req;
  logic [AWIDTH-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DWIDTH-1:0] if_rdata;
  logic              ls_req;
  logic              ls_we;
  logic [AWIDTH-1:0] ls_addr;
  logic [DWIDTH-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DWIDTH-1:0] ls_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_wdata;
  logic [DWIDTH-1:0] mem_rdata;
  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one-access-per-cycle sharing of a sync memory between fetch and load/store
module mem_port_arbiter #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 8,
  parameter int STARVE_MAX = 3
) (
  input logic clk,
  input logic rst_n,
  mem_port_arbiter_if.slave bus
);
  logic [3:0] starve_cnt;
  logic [1:0] pend;
  logic [DWIDTH-1:0] if_hold, ls_hold;
  logic [AWIDTH-1:0] addr;
  logic gi, gl, at_max;
  always_comb begin
    at_max = starve_cnt == 4'(STARVE_MAX);
    gi = rst_n && bus.if_req && (!bus.ls_req || at_max);
    gl = rst_n && bus.ls_req && !gi;
    addr = gl ? bus.ls_addr : gi ? bus.if_addr : '0;
  end
  assign bus.if_gnt = gi;
  assign bus.ls_gnt = gl;
  assign bus.mem_en = gi || gl;
  assign bus.mem_we = gl && bus.ls_we;
  assign bus.mem_addr = addr;
  assign bus.mem_wdata = (gl && bus.ls_we) ? bus.ls_wdata : '0;
  assign bus.if_rvalid = pend[0];
  assign bus.ls_rvalid = pend[1];
  // responses pass mem_rdata straight through, then hold it until the next one
  assign bus.if_rdata = pend[0] ? bus.mem_rdata : if_hold;
  assign bus.ls_rdata = pend[1] ? bus.mem_rdata : ls_hold;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      starve_cnt <= '0;
      pend <= '0;
      if_hold <= '0;
      ls_hold <= '0;
    end else begin
      starve_cnt <= (gi || !bus.if_req) ? 4'd0 : (gl && !at_max) ? starve_cnt + 4'd1 : starve_cnt;
      pend <= {gl && !bus.ls_we, gi};
      if (pend[0]) if_hold <= bus.mem_rdata;
      if (pend[1]) ls_hold <= bus.mem_rdata;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random and directed traffic checked against a queue-based reference model
module tb_mem_port_arbiter;
  localparam int DW = 16, AW = 8, SM = 3;
  typedef struct {
    bit rst, gi, gl, we, ifv, lsv;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } exp_t;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;
  mem_port_arbiter_if #(.DWIDTH(DW), .AWIDTH(AW)) bus();
  mem_port_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .STARVE_MAX(SM)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [DW-1:0] mem [256];
  logic [DW-1:0] ref_mem [256];
  always @(posedge clk)
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else bus.mem_rdata <= mem[bus.mem_addr];
    end
  exp_t exp_q[$];
  logic [DW-1:0] if_q[$], ls_q[$];
  int wait_ls = 0;
  bit prev_if = 0, prev_ls = 0;
  int errs = 0, checks = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask
  task automatic cyc(input bit ir, input logic [AW-1:0] ia, input bit lr, input bit lw,
                     input logic [AW-1:0] la, input logic [DW-1:0] ld);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = 1;
    bus.if_req = ir; bus.if_addr = ia;
    bus.ls_req = lr; bus.ls_we = lw; bus.ls_addr = la; bus.ls_wdata = ld;
    e = '{default: 0};
    e.gi = ir && (!lr || wait_ls >= SM);
    e.gl = lr && !e.gi;
    e.we = e.gl && lw;
    e.addr = e.gl ? la : e.gi ? ia : '0;
    e.wd = e.we ? ld : '0;
    e.ifv = prev_if;
    e.lsv = prev_ls;
    if (e.gi) if_q.push_back(ref_mem[ia]);
    if (e.gl && !lw) ls_q.push_back(ref_mem[la]);
    if (e.we) ref_mem[la] = ld;
    wait_ls = (e.gi || !ir) ? 0 : (wait_ls + 1 > SM ? SM : wait_ls + 1);
    prev_if = e.gi;
    prev_ls = e.gl && !lw;
    exp_q.push_back(e);
  endtask
  task automatic rcyc();
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = 0;
    bus.if_req = 1; bus.if_addr = AW'($urandom);
    bus.ls_req = 1; bus.ls_we = 1'($urandom); bus.ls_addr = AW'($urandom); bus.ls_wdata = DW'($urandom);
    e = '{default: 0};
    e.rst = 1;
    if_q.delete();
    ls_q.delete();
    wait_ls = 0;
    prev_if = 0;
    prev_ls = 0;
    exp_q.push_back(e);
  endtask
  task automatic idle();
    cyc(0, '0, 0, 0, '0, '0);
  endtask
  initial begin
    exp_t e;
    logic [DW-1:0] last_if = '0, last_ls = '0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("grant_bus", {bus.if_gnt, bus.ls_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata},
            {e.gi, e.gl, e.gi | e.gl, e.we, e.addr, e.wd});
        chk("if_rvalid", bus.if_rvalid, e.ifv);
        chk("ls_rvalid", bus.ls_rvalid, e.lsv);
        if (e.rst) begin
          last_if = '0;
          last_ls = '0;
        end
        if (e.ifv) begin
          if (if_q.size() == 0) begin
            checks++; errs++;
            $display("FAIL if_q_underflow: got response want none");
          end else last_if = if_q.pop_front();
        end
        if (e.lsv) begin
          if (ls_q.size() == 0) begin
            checks++; errs++;
            $display("FAIL ls_q_underflow: got response want none");
          end else last_ls = ls_q.pop_front();
        end
        chk("if_rdata", bus.if_rdata, last_if);
        chk("ls_rdata", bus.ls_rdata, last_ls);
      end
    end
  end
  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = DW'($urandom);
      mem[i] = ref_mem[i];
    end
    ref_mem[8'h10] = 16'hABCD; mem[8'h10] = 16'hABCD;
    ref_mem[8'h01] = 16'h0011; mem[8'h01] = 16'h0011;
    ref_mem[8'h02] = 16'h0022; mem[8'h02] = 16'h0022;
    bus.if_req = 0; bus.if_addr = '0;
    bus.ls_req = 0; bus.ls_we = 0; bus.ls_addr = '0; bus.ls_wdata = '0;
    repeat (3) rcyc();
    idle();
    cyc(1, 8'h10, 0, 0, '0, '0);
    idle();
    idle();
    for (int i = 0; i < 8; i++) cyc(1, AW'($urandom), 1, 0, AW'($urandom), '0);
    idle();
    cyc(0, '0, 1, 1, 8'h64, 16'h1234);
    cyc(1, 8'h64, 0, 0, '0, '0);
    idle();
    cyc(0, '0, 1, 0, 8'h01, '0);
    cyc(0, '0, 1, 0, 8'h02, '0);
    idle();
    idle();
    cyc(1, 8'h10, 0, 0, '0, '0);
    rcyc();
    for (int i = 0; i < 4; i++) cyc(1, AW'($urandom), 1, 0, AW'($urandom), '0);
    idle();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) rcyc();
      else cyc(1'($urandom), AW'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
               AW'($urandom_range(0, 15)), DW'($urandom));
    end
    idle();
    idle();
    @(negedge clk);
    #1;
    chk("if_q_drained", 64'(if_q.size()), 64'd0);
    chk("ls_q_drained", 64'(ls_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port synchronous program/data memory between two requesters: instruction fetch (if_*) and load/store (ls_*).
- Grants one access per cycle, drives the memory port, and routes read data back to the requester that issued the read.
- Load/store has priority over fetch. A bounded starvation counter guarantees fetch progress.
- Sits between the CPU core's fetch/execute units and the memory.

Parameters:
- DWIDTH, 16, data word width.
- AWIDTH, 8, address width; memory depth 2**AWIDTH.
- STARVE_MAX, 3, maximum consecutive load/store grants while fetch is waiting (legal range 1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch read request; held until if_gnt.
- if_addr  in  AWIDTH  fetch address.
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  if_rdata valid (one-cycle pulse).
- if_rdata  out  DWIDTH  fetch read data.
- ls_req  in  1  load/store request; held until ls_gnt.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  AWIDTH  load/store address.
- ls_wdata  in  DWIDTH  store data.
- ls_gnt  out  1  load/store accepted this cycle.
- ls_rvalid  out  1  ls_rdata valid (one-cycle pulse, loads only).
- ls_rdata  out  DWIDTH  load data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AWIDTH  memory address.
- mem_wdata  out  DWIDTH  memory write data.
- mem_rdata  in  DWIDTH  memory read data, valid the cycle after a read strobe.

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous and active-low. While reset is asserted, all registers clear, all grant, valid and mem_* outputs are 0, and if_rdata and ls_rdata are 0.
- Arbitration is combinational within the cycle. Grants and mem_* are derived from the req inputs and the registered starve_cnt.
- Selection each cycle:
  - Only ls_req high: grant ls.
  - Only if_req high: grant if.
  - Both high: grant if when starve_cnt == STARVE_MAX, otherwise grant ls.
  - Neither high: no grant; mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- At most one grant per cycle. When a grant is issued:
  - mem_en = 1.
  - mem_addr = the granted requester's address.
  - mem_we = ls_we when ls is granted, else 0.
  - mem_wdata = ls_wdata when ls is granted with ls_we = 1, else 0.
- starve_cnt is a 4-bit register, updated on clk:
  - Increments (saturating at STARVE_MAX) when ls is granted while if_req = 1.
  - Clears to 0 when if is granted, or when if_req = 0.
- In-flight tracking uses a 2-bit registered pending tag (bit0 = fetch read, bit1 = load), set on the granting edge. Stores never set a tag.
- Read latency is 1 cycle. Grant in cycle N gives the matching rvalid = 1 in cycle N+1, with rdata = mem_rdata in that cycle. rdata is captured into a holding register and held until the next response to the same requester.
- Full throughput: back-to-back grants every cycle are allowed, so responses can occur on consecutive cycles.
- Stores have no response. ls_gnt in the store cycle is the completion indication.
- Read-after-write to the same address: a store granted in cycle N is visible to any read granted in cycle N+1 or later.
- Reset asserted while a read is in flight: the pending tag clears, no rvalid is issued, and the response is discarded.
- A requester that drops req without a grant is not an error. The arbiter does not latch requests.
- Address wrap is the requester's responsibility. The arbiter passes AWIDTH bits unchanged.

Test Plan:
- Hold rst_n = 0 for 3 cycles with both reqs high -> all grant, rvalid and mem_* outputs stay 0, and both rdata outputs are 0.
- Memory[0x10] = 0xABCD; if_req with if_addr = 0x10 for one cycle -> if_gnt = 1, mem_en = 1 and mem_addr = 0x10 in that cycle; if_rvalid = 1 with if_rdata = 0xABCD the next cycle; ls_rvalid stays 0.
- STARVE_MAX = 3; if_req and ls_req (loads) held high for 8 cycles -> grant sequence ls, ls, ls, if, ls, ls, ls, if; responses are routed to the matching rvalid one cycle after each grant.
- Store ls_addr = 0x64, ls_wdata = 0x1234 in cycle N, then fetch from 0x64 in cycle N+1 -> mem_we = 1 only in cycle N, no ls_rvalid, if_rdata = 0x1234 in cycle N+2.
- Back-to-back loads from 0x01 (=0x0011) and 0x02 (=0x0022) -> ls_rvalid high for two consecutive cycles with ls_rdata 0x0011 then 0x0022.
- Fetch granted in cycle N, rst_n pulsed low during cycle N+1 -> if_rvalid never asserts and starve_cnt reads 0 after reset release.
